// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if
// Handshake and data bundle for the shift-and-add multiplier.
//   start   : request a new multiplication (honoured only when the unit is idle)
//   sgn     : 1 = two's-complement operands, 0 = unsigned; sampled with start
//   data_in : operand A in the start cycle, operand B in the following cycle
//   busy    : high while operand B is loaded and while the product is computed
//   done    : one-cycle pulse when result has just been updated
//   result  : registered 2*WIDTH-bit product, held until the next completion
// The master modport is the requester, the slave modport is the multiplier.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic                   sgn;
  logic [WIDTH-1:0]       data_in;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     result;

  modport master (
    output start,
    output sgn,
    output data_in,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  sgn,
    input  data_in,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
// Sequential WIDTH x WIDTH multiplier using shift-and-add on operand
// magnitudes, one multiplier bit per cycle, terminating as soon as the
// remaining multiplier bits are all zero. Signed operation multiplies the
// magnitudes and negates the product when the operand signs differ.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, aborts any operation in flight
//   bus : shift_add_multiplier_if slave modport (start/sgn/data_in in,
//         busy/done/result out)
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_multiplier_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOADB = 2'd1;
  localparam logic [1:0] ST_CALC  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]           state;
  logic [WIDTH-1:0]     a_reg;
  logic                 sgn_reg;
  logic                 neg;
  logic [2*WIDTH-1:0]   p;
  logic [2*WIDTH-1:0]   ms;
  logic [WIDTH-1:0]     bs;
  logic [2*WIDTH-1:0]   result_reg;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;

  // Magnitudes for the LOADB cycle. Negating the most-negative value wraps
  // back to itself, which read as unsigned is exactly its magnitude.
  always_comb begin
    mag_a = a_reg;
    mag_b = bus.data_in;
    if (sgn_reg && a_reg[WIDTH-1]) begin
      mag_a = -a_reg;
    end
    if (sgn_reg && bus.data_in[WIDTH-1]) begin
      mag_b = -bus.data_in;
    end
  end

  // Main sequencer: capture A, capture B and form magnitudes, then add and
  // shift until the multiplier register empties, then publish the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      a_reg      <= '0;
      sgn_reg    <= 1'b0;
      neg        <= 1'b0;
      p          <= '0;
      ms         <= '0;
      bs         <= '0;
      result_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_reg   <= bus.data_in;
            sgn_reg <= bus.sgn;
            state   <= ST_LOADB;
          end
        end
        ST_LOADB: begin
          neg   <= sgn_reg & (a_reg[WIDTH-1] ^ bus.data_in[WIDTH-1]);
          p     <= '0;
          ms    <= {{WIDTH{1'b0}}, mag_a};
          bs    <= mag_b;
          state <= ST_CALC;
        end
        ST_CALC: begin
          if (bs != '0) begin
            if (bs[0]) begin
              p <= p + ms;
            end
            ms <= ms << 1;
            bs <= bs >> 1;
          end else begin
            result_reg <= neg ? -p : p;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = (state == ST_LOADB) || (state == ST_CALC);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = result_reg;

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Parametrised sequential multiplier, the successor to the team's repeated-addition multiplier. It loads two WIDTH-bit operands over a shared `data_in` bus on consecutive cycles and multiplies by shift-and-add, one multiplier bit per cycle, stopping early once the remaining multiplier bits are zero. It supports unsigned and two's-complement signed operation, selected per operation, and returns a registered 2·WIDTH-bit product with a busy/done handshake.

## Interface
- `WIDTH`, default 8, operand width in bits (≥ 2); the product is 2·WIDTH bits.

- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  begin an operation; accepted only in IDLE.
- `sgn`  input  1  sampled with `start`: 1 = signed two's-complement, 0 = unsigned.
- `data_in`  input  WIDTH  operand A in the `start` cycle, operand B in the next cycle.
- `busy`  output  1  high in LOADB and CALC.
- `done`  output  1  one-cycle pulse when `result` is updated.
- `result`  output  2·WIDTH  product, registered, held until the next completion.

## Operation
- The state machine has four states: IDLE, LOADB, CALC and DONE.
- IDLE, with `start`=1:
  - Capture A from `data_in` and latch `sgn`.
  - Go to LOADB.
- IDLE, with `start`=0: stay in IDLE.
- LOADB:
  - Capture B from `data_in` unconditionally.
  - Form the magnitudes |A| and |B|. In signed mode, a negative operand is negated; in unsigned mode, the magnitude is the raw value.
  - Record `neg` = signA XOR signB when signed, else 0.
  - Clear the accumulator P (2·WIDTH bits).
  - Load the multiplicand shift register Ms with |A|, zero-extended to 2·WIDTH bits.
  - Load the multiplier shift register Bs with |B| (WIDTH bits).
  - Go to CALC.
- CALC, with Bs ≠ 0:
  - If Bs[0], then P ← P + Ms.
  - Ms ← Ms << 1; Bs ← Bs >> 1.
  - Stay in CALC.
- CALC, with Bs = 0:
  - `result` ← `neg` ? −P (two's complement, 2·WIDTH bits) : P.
  - Go to DONE.
- DONE:
  - `done`=1 for this cycle only.
  - Go to IDLE unconditionally.
- Magnitude rules:
  - The most-negative operand −2^(WIDTH−1) has magnitude 2^(WIDTH−1), which fits in WIDTH unsigned bits.
  - The maximum product magnitude, 2^(2·WIDTH−2) signed or (2^WIDTH−1)² unsigned, fits in 2·WIDTH bits. No overflow is possible and no saturation is applied.
- `start` in any state other than IDLE is ignored. It does not queue, and it does not alter the operation in flight.
- `sgn` and `data_in` are don't-care outside the two capture cycles.
- Reset: state ← IDLE, `busy`=0, `done`=0, `result`=0, internal registers cleared.
  - Reset takes effect on the next edge, from any state including mid-CALC.
  - An aborted operation never produces `done`.

## Timing
- Define n as the bit length of |B| (n = 0 when B = 0). n ≤ WIDTH in both modes.
- Cycle T: `start` is high and A is on `data_in`.
- Cycle T+1: state LOADB, `busy`=1, B is on `data_in`.
- Cycles T+2 to T+2+n: CALC. This is n add/shift cycles plus one terminating cycle.
- Cycle T+3+n: `done`=1 and the new `result` is valid; `busy`=0.
- Latency from `start` to `done` is 3+n cycles: minimum 3 (B = 0), maximum 3+WIDTH.
- The earliest next accepted `start` is cycle T+4+n, in IDLE. `start` high during DONE is ignored.
- `result` changes only on the edge entering DONE, or on reset.

## Test plan
- Reset: assert `rst` for 2 cycles with `start` toggling -> `busy`=0, `done`=0, `result`=0; no `done` pulse follows.
- Unsigned, WIDTH=8: `sgn`=0, A=13, B=11 -> `result`=143 (0x008F). `done` pulses exactly at T+7 (n=4) for one cycle. `busy` is high from T+1 to T+6.
- Zero and full-range unsigned:
  - A=200, B=0 -> `result`=0, `done` at T+3.
  - A=255, B=255 -> `result`=0xFE01, `done` at T+11.
- Signed:
  - `sgn`=1, A=0x80, B=0x80 -> `result`=0x4000, `done` at T+11.
  - A=0xFD (−3), B=0x05 -> `result`=0xFFF1 (−15), `done` at T+6.
  - A=0x7F, B=0xFF (−1) -> `result`=0xFF81, `done` at T+4.
- Protocol:
  - `start` pulsed during LOADB, CALC and DONE -> ignored; the product and `done` timing are unchanged.
  - Between operations, `result` holds its previous value.
- Reset mid-operation: `rst` in the third CALC cycle of 255×255 -> next cycle IDLE, `result`=0, no `done`. A following 6×7 operation -> 42, `done` at T+6.
